// File: rtl/riscv_core_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_boot_pkg
// Description : Shared types and constants for the boot loader: loader FSM
//               states, bytes per assembled word and the frame field enum.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_core_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } boot_state_e;

  localparam int BOOT_WORD_BYTES = 4;

  // Which field of a frame a byte belongs to.
  typedef enum logic [1:0] {
    F_LEN  = 2'd0,
    F_DATA = 2'd1,
    F_CSUM = 2'd2
  } boot_frame_field_e;

endpackage
`default_nettype wire

// File: rtl/riscv_core_boot_word_asm.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_boot_word_asm
// Description : Assembles little-endian 32-bit words from accepted bytes.
//               Byte k of a word lands in bits [8k+7:8k]; o_word_valid pulses
//               combinationally with the 4th accepted byte, and o_word then
//               carries the complete word.
// Ports       : i_clk, i_rst_n (async active-low), i_clear (sync counter
//               clear), i_byte_accept, i_byte_data[7:0],
//               o_word[31:0], o_word_valid
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_boot_word_asm
  import riscv_core_boot_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_accept,
  input  logic [7:0]  i_byte_data,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(BOOT_WORD_BYTES - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (i_clear) begin
      cnt_d = 2'd0;
    end else if (i_byte_accept) begin
      shift_d[{cnt_q, 3'b000} +: 8] = i_byte_data;
      cnt_d                         = cnt_q + 2'd1;
    end
  end

  // The last byte bypasses the shift register so the FSM sees the full
  // word on the same edge that accepts it.
  assign o_word       = {i_byte_data, shift_q[23:0]};
  assign o_word_valid = i_byte_accept && !i_clear && (cnt_q == LAST_BYTE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_core_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : riscv_core_boot_loader
// Description : Framed boot-stream loader. Parses LEN, LEN payload words and
//               an XOR checksum, writes payload words to memory from word 0,
//               and releases the core reset only after a matching checksum.
// Ports       : i_riscv_core_clk, i_riscv_core_rst_n (async active-low),
//               i_boot_byte_valid/i_boot_byte_data/o_boot_byte_ready (stream),
//               o_boot_mem_we/o_boot_mem_addr/o_boot_mem_wdata (memory write),
//               o_boot_core_rst_n, o_boot_busy, o_boot_done, o_boot_error
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_core_boot_loader
  import riscv_core_boot_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 13,
  parameter int MAX_WORDS = 5000
) (
  input  logic              i_riscv_core_clk,
  input  logic              i_riscv_core_rst_n,
  input  logic              i_boot_byte_valid,
  input  logic [7:0]        i_boot_byte_data,
  output logic              o_boot_byte_ready,
  output logic              o_boot_mem_we,
  output logic [ADDR_W-1:0] o_boot_mem_addr,
  output logic [XLEN-1:0]   o_boot_mem_wdata,
  output logic              o_boot_core_rst_n,
  output logic              o_boot_busy,
  output logic              o_boot_done,
  output logic              o_boot_error
);

  boot_state_e       state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;      // one extra bit: LEN may equal 2^ADDR_W
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   xor_q, xor_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              core_rst_n_q, core_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        byte_accept;
  logic        asm_clear;
  logic [31:0] asm_word;
  logic        asm_word_valid;

  assign byte_accept = i_boot_byte_valid && ready_q;
  assign asm_clear   = (state_q == S_DONE) || (state_q == S_ERR);

  riscv_core_boot_word_asm u_word_asm (
    .i_clk         (i_riscv_core_clk),
    .i_rst_n       (i_riscv_core_rst_n),
    .i_clear       (asm_clear),
    .i_byte_accept (byte_accept),
    .i_byte_data   (i_boot_byte_data),
    .o_word        (asm_word),
    .o_word_valid  (asm_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    error_d      = error_q;

    if (asm_word_valid) begin
      case (state_q)
        S_LEN: begin
          idx_d = '0;
          xor_d = '0;
          len_d = asm_word[ADDR_W:0];
          if (asm_word > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (asm_word == 32'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = asm_word;
          xor_d   = xor_q ^ asm_word;
          idx_d   = idx_q + ADDR_W'(1);
          if (({1'b0, idx_q} + (ADDR_W + 1)'(1)) == len_q) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (asm_word == xor_q) begin
            state_d      = S_DONE;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Ready and busy both track the next state so they drop together with
    // the terminal-state entry.
    ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
    busy_d  = ready_d && (busy_q || byte_accept);
  end

  always_ff @(posedge i_riscv_core_clk or negedge i_riscv_core_rst_n) begin
    if (!i_riscv_core_rst_n) begin
      state_q      <= S_LEN;
      len_q        <= '0;
      idx_q        <= '0;
      xor_q        <= '0;
      ready_q      <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign o_boot_byte_ready = ready_q;
  assign o_boot_mem_we     = we_q;
  assign o_boot_mem_addr   = addr_q;
  assign o_boot_mem_wdata  = wdata_q;
  assign o_boot_core_rst_n = core_rst_n_q;
  assign o_boot_busy       = busy_q;
  assign o_boot_done       = done_q;
  assign o_boot_error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_core_boot_loader
// Description : Self-checking bench for riscv_core_boot_loader. Frames are
//               held as word lists; expected outputs after each accepted byte
//               are derived from the frame contents and the byte count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_core_boot_loader;
  import riscv_core_boot_pkg::*;

  localparam int ADDR_W    = 13;
  localparam int MAX_WORDS = 5000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'd0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  riscv_core_boot_loader #(
    .XLEN      (32),
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .i_riscv_core_clk   (clk),
    .i_riscv_core_rst_n (rst_n),
    .i_boot_byte_valid  (byte_valid),
    .i_boot_byte_data   (byte_data),
    .o_boot_byte_ready  (byte_ready),
    .o_boot_mem_we      (mem_we),
    .o_boot_mem_addr    (mem_addr),
    .o_boot_mem_wdata   (mem_wdata),
    .o_boot_core_rst_n  (core_rst_n),
    .o_boot_busy        (busy),
    .o_boot_done        (done),
    .o_boot_error       (error)
  );

  always #5 clk = ~clk;

  // Small memory image fed by the write port.
  logic [31:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_we && (mem_addr < 16)) mem[mem_addr[3:0]] <= mem_wdata;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Current frame, as 32-bit words: LEN, payload..., CSUM.
  logic [31:0] fw [$];

  function automatic logic [7:0] frame_byte(int i);
    logic [31:0] w;
    w = fw[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  function automatic int frame_len();
    return (fw[0] > 32'(MAX_WORDS)) ? -1 : int'(fw[0]);
  endfunction

  // Bytes accepted before the loader reaches its terminal state.
  function automatic int term_bytes();
    int len;
    len = frame_len();
    return (len < 0) ? 4 : 4 * (len + 2);
  endfunction

  function automatic bit frame_ok();
    int len;
    logic [31:0] x;
    len = frame_len();
    if (len < 0) return 1'b0;
    x = 32'd0;
    for (int k = 1; k <= len; k++) x = x ^ fw[k];
    return x == fw[len + 1];
  endfunction

  function automatic boot_frame_field_e field_of(int n);
    int w;
    w = (n - 1) / 4;
    if (w == 0) return F_LEN;
    if (w <= frame_len()) return F_DATA;
    return F_CSUM;
  endfunction

  // Compare outputs against the state expected after n accepted bytes;
  // acc_now marks that byte n was accepted on the edge just passed.
  task automatic expect_state(input int n, input bit acc_now, input string tag);
    bit fin, ok, e_we;
    int len, w;
    string t;
    len  = frame_len();
    fin  = n >= term_bytes();
    ok   = fin && frame_ok();
    w    = n / 4 - 1;
    e_we = acc_now && (n % 4 == 0) && (len > 0) && (w >= 1) && (w <= len);
    t    = (n > 0) ? $sformatf("%s_b%0d_%s", tag, n, field_of(n).name()) : $sformatf("%s_b0", tag);
    check({t, "_ctl"}, {58'd0, byte_ready, mem_we, core_rst_n, busy, done, error},
          {58'd0, !fin, e_we, ok, (!fin && n > 0), ok, (fin && !ok)});
    if (e_we) begin
      check({t, "_addr"}, 64'(mem_addr), 64'(w - 1));
      check({t, "_wdata"}, 64'(mem_wdata), 64'(fw[w]));
    end
  endtask

  // Streams the frame plus four trailing bytes that must be refused.
  // stop_after >= 0 ends the stream after that many accepted bytes.
  task automatic run_frame(input string tag, input int max_gap, input int stop_after);
    int n, total, g;
    bit acc;
    n     = 0;
    total = fw.size() * 4 + 4;
    for (int i = 0; i < total; i++) begin
      if (stop_after >= 0 && n == stop_after) break;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        byte_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        expect_state(n, 1'b0, {tag, "_gap"});
      end
      byte_valid = 1'b1;
      byte_data  = (i < fw.size() * 4) ? frame_byte(i) : 8'($urandom);
      acc        = byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) n++;
      expect_state(n, acc, tag);
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    byte_valid = 1'b0;
    #1;
    check({tag, "_rst_ctl"}, {58'd0, byte_ready, mem_we, core_rst_n, busy, done, error},
          {58'd0, 6'b100000});
    check({tag, "_rst_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_rst_wdata"}, 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int len;
    logic [31:0] x;

    do_reset("init");

    // Back-to-back valid frame
    fw = {32'd2, 32'h00500093, 32'h00A00113, 32'h00F00180};
    run_frame("valid", 0, -1);
    check("valid_mem0", 64'(mem[0]), 64'h00500093);
    check("valid_mem1", 64'(mem[1]), 64'h00A00113);

    do_reset("pre_badcs");
    fw = {32'd2, 32'h00500093, 32'h00A00113, 32'h00F00181};
    run_frame("badcs", 0, -1);

    do_reset("pre_empty");
    fw = {32'd0, 32'd0};
    run_frame("empty", 0, -1);

    do_reset("pre_over");
    fw = {32'h00001389};
    run_frame("over", 0, -1);

    do_reset("pre_gap");
    mem[0] = 32'd0;
    mem[1] = 32'd0;
    fw = {32'd2, 32'h00500093, 32'h00A00113, 32'h00F00180};
    run_frame("gapped", 5, -1);
    check("gapped_mem0", 64'(mem[0]), 64'h00500093);
    check("gapped_mem1", 64'(mem[1]), 64'h00A00113);

    // Reset after 6 payload bytes, then a fresh frame
    do_reset("pre_mid");
    fw = {32'd2, 32'hDEADBEEF, 32'h12345678, 32'hCC99E897};
    run_frame("mid", 0, 10);
    do_reset("mid");
    fw = {32'd2, 32'h00500093, 32'h00A00113, 32'h00F00180};
    run_frame("after_mid", 0, -1);
    check("after_mid_mem0", 64'(mem[0]), 64'h00500093);
    check("after_mid_mem1", 64'(mem[1]), 64'h00A00113);

    // Randomized frames, including random length overflow and bad checksums
    for (int r = 0; r < 8; r++) begin
      do_reset($sformatf("pre_rnd%0d", r));
      len = int'($urandom_range(6, 0));
      fw  = {32'(len)};
      x   = 32'd0;
      for (int k = 0; k < len; k++) begin
        fw.push_back($urandom);
        x = x ^ fw[k + 1];
      end
      if ($urandom_range(1, 0) == 1) x = x ^ (32'd1 << $urandom_range(31, 0));
      fw.push_back(x);
      if (r == 7) fw = {32'(MAX_WORDS + 1 + int'($urandom_range(1000, 0)))};
      run_frame($sformatf("rnd%0d", r), 3, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_core_boot_loader.md
# riscv_core_boot_loader

Boot-time program loader in front of `riscv_core_top`. It receives a framed little-endian byte stream (UART/JTAG bridge or bench driver), assembles 32-bit instruction words and writes them into the main instruction/data memory starting at word 0. The core is held in reset until a complete frame with a matching checksum has been written. This replaces hierarchical memory preloading with a synthesizable load path.

## Interface
Parameters:
- `XLEN`, 32, data word width; fixed at 32.
- `ADDR_W`, 13, word-address width of the memory write port.
- `MAX_WORDS`, 5000, largest accepted payload length in words; must be ≤ 2^ADDR_W.

Ports:
- `i_riscv_core_clk`  in  1  system clock.
- `i_riscv_core_rst_n`  in  1  asynchronous active-low reset.
- `i_boot_byte_valid`  in  1  the byte on `i_boot_byte_data` is valid.
- `i_boot_byte_data`  in  8  stream byte.
- `o_boot_byte_ready`  out  1  loader accepts a byte this cycle.
- `o_boot_mem_we`  out  1  one-cycle memory write strobe.
- `o_boot_mem_addr`  out  ADDR_W  memory word address.
- `o_boot_mem_wdata`  out  32  memory write data.
- `o_boot_core_rst_n`  out  1  core reset; low holds the core in reset.
- `o_boot_busy`  out  1  a frame is in progress.
- `o_boot_done`  out  1  load completed; sticky until reset.
- `o_boot_error`  out  1  length or checksum failure; sticky until reset.

## Operation
- A byte transfers on a rising clock edge when `valid && ready` are both high.
- Frame layout, all fields little-endian 32-bit: `LEN` (word count), then `LEN` payload words, then `CSUM`, where `CSUM` is the XOR of all payload words.
- FSM states are `S_LEN`, `S_DATA`, `S_CSUM`, `S_DONE` and `S_ERR`. Reset enters `S_LEN`.
- A 2-bit byte counter fills a 32-bit shift register. Byte k goes to bits [8k+7:8k]. The word completes on the 4th accepted byte.
- `S_LEN` word complete:
  - `LEN > MAX_WORDS` → `S_ERR`.
  - `LEN == 0` → `S_CSUM`.
  - Otherwise → `S_DATA`. Clear the word index and running XOR.
- `S_DATA` word complete:
  - Register a write: `addr = index`, `wdata = word`.
  - Update XOR. Increment index.
  - After word `LEN-1` → `S_CSUM`.
- `S_CSUM` word complete:
  - Match → `S_DONE`.
  - Mismatch → `S_ERR`.
- `S_DONE` / `S_ERR` are terminal. `ready` = 0 and stream input is ignored. Only reset leaves them.
- `o_boot_busy` = 1 from the first accepted byte until `S_DONE`/`S_ERR` is entered.
- All arithmetic is unsigned. The index is `ADDR_W` bits and never wraps, because `MAX_WORDS` ≤ 2^ADDR_W.

## Timing
- Reset values (asynchronous):
  - `o_boot_byte_ready`=1 (registered; reflects state `S_LEN`).
  - `o_boot_mem_we`=0, `addr`=0, `wdata`=0.
  - `o_boot_core_rst_n`=0.
  - `busy`/`done`/`error`=0.
- `o_boot_byte_ready` is high in `S_LEN`/`S_DATA`/`S_CSUM`, including the write cycle, so there is no stream back-pressure while loading. It falls in the cycle after the final `CSUM` byte.
- Memory write latency: `o_boot_mem_we` is high for exactly the one cycle after the 4th byte of a payload word is accepted. `addr` and `wdata` are valid in that same cycle. The memory is assumed to take one write per cycle.
- Terminal-state latency: `o_boot_done` and `o_boot_core_rst_n` rise together one cycle after the last `CSUM` byte. `o_boot_error` rises one cycle after the offending byte.
- Idle gaps (`valid` low) between bytes pause assembly without loss.
- Reset asserted mid-frame:
  - All state clears immediately and the core is re-held in reset.
  - Memory words already written remain in memory.
  - The next frame restarts at `LEN`.

## Structure
- Package `riscv_core_boot_pkg` holds:
  - the `boot_state_e` enum;
  - the `BOOT_WORD_BYTES` = 4 constant;
  - the `boot_frame_field_e` field enum used by the bench.
- One sub-module, `riscv_core_boot_word_asm`, contains the byte counter, the shift register and the `word_valid` pulse, with its own clear input.
- The top holds the FSM, length/index/XOR registers and output registers.
- The core wrapper connects `o_boot_core_rst_n` AND `i_riscv_core_rst_n` to the core's reset. The memory write port is muxed with the core's port while `o_boot_core_rst_n`=0.

## Test plan
- **Valid frame:** `LEN`=2, words 0x00500093 and 0x00A00113, `CSUM`=0x00F00180, streamed back-to-back.
  - Writes addr0←0x00500093, then addr1←0x00A00113.
  - `done`=1 and `core_rst_n`=1 one cycle after the last byte; `error`=0.
- **Bad checksum:** same frame with `CSUM`=0x00F00181.
  - Both writes occur.
  - Then `error`=1, `ready`=0, `core_rst_n` stays 0, `done` stays 0.
- **Empty payload:** `LEN`=0, `CSUM`=0.
  - No `we` pulse.
  - `done`=1 eight byte-transfers after start.
- **Oversize length:** `LEN`=5001 (0x00001389).
  - `error`=1 one cycle after the 4th byte.
  - No writes; following bytes are not accepted.
- **Gapped stream:** same as the valid frame with random 0–5 cycle `valid` gaps.
  - Identical writes and final state to the valid-frame case.
- **Reset mid-payload:** assert reset after 6 payload bytes (one word written).
  - All outputs return to reset values asynchronously.
  - A fresh valid frame afterwards loads correctly and sets `done`.
